control_spi_tx: RTL and testbench
=================================

CONTROL_SPI_TX -- requirements
Module: control_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning Main_Clock cycles per SCK half-period (legal range 2-255).
REQ-002 SHALL have port Main_Clock  input  1  system clock (48 MHz); all logic on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_Start  input  1  single-cycle request to send one frame.
REQ-005 SHALL have ports i_Data0..i_Data4  input  16 each  control words: frequency, harmonic scale, scale initial, frequency offset, comb interval.
REQ-006 SHALL have port o_SPI_CS  output  1  frame select, active-low.
REQ-007 SHALL have port o_SPI_Clock  output  1  SPI clock, idle low.
REQ-008 SHALL have port o_SPI_Data  output  1  serial data, MSB first.
REQ-009 SHALL have port o_Busy  output  1  high from accepted start until ready for the next start.
REQ-010 SHALL have port o_Done  output  1  one-cycle pulse on frame completion.

Function
REQ-011 SHALL act as SPI master for the 5-word control frame consumed by the ADC SPI receiver: mode 0; receiver samples on SCK rising edge; data changes only while SCK is low.
REQ-012 SHALL send i_Data0 first, then i_Data1..i_Data4, each MSB first: 80 bits per frame.
REQ-013 SHALL use states IDLE, SETUP, SCK_HIGH, SCK_LOW, GAP.
REQ-014 SHALL accept i_Start only in IDLE and latch all five words into a shift register in that cycle; o_Busy rises in the next cycle.
REQ-015 SHALL ignore i_Start while o_Busy is high; the frame in progress is unaffected.
REQ-016 SHALL ignore changes on i_Data0..4 after the latch cycle until the next accepted start.
REQ-017 SETUP: SHALL drive CS low and o_SPI_Data = bit 79 for CLK_DIV cycles with SCK low, then enter SCK_HIGH.
REQ-018 SCK_HIGH: SHALL hold SCK high for CLK_DIV cycles, then enter SCK_LOW.
REQ-019 SCK_LOW: SHALL drive SCK low and present the next bit on its first cycle, then hold for CLK_DIV cycles.
REQ-020 SHALL return from SCK_LOW to SCK_HIGH while bits remain; after the SCK_LOW that follows the last bit, SHALL enter GAP.
REQ-021 SHALL keep CS low from the first SETUP cycle through the last SCK_LOW cycle: CLK_DIV*(1+2*bits) cycles (644 cycles for 80 bits, CLK_DIV=4).
REQ-022 On GAP entry, SHALL drive CS high and o_SPI_Data low, and pulse o_Done for exactly that cycle.
REQ-023 SHALL hold GAP for CLK_DIV cycles, then enter IDLE and deassert o_Busy; a start is accepted in the first IDLE cycle.
REQ-024 SHALL count bits with a 7-bit counter that terminates exactly at the frame length, with no wrap or extra SCK edge.
REQ-025 SHALL produce exactly bits rising SCK edges per frame.

Reset
REQ-026 SHALL, while Reset is high, force state IDLE, o_SPI_CS=1, o_SPI_Clock=0, o_SPI_Data=0, o_Busy=0, o_Done=0, and clear the counters.
REQ-027 SHALL, on Reset mid-frame, abort in the next cycle (CS high, SCK low) without pulsing o_Done.
REQ-028 SHALL give Reset priority when Reset and i_Start are high in the same cycle; the start is discarded.

Configuration
REQ-029 Macro CONTROL_SPI_TX_CHECKSUM_EN defined: SHALL append a sixth word equal to the sum of i_Data0..4 mod 2^16, captured at latch; frame = 96 bits.
REQ-030 CONTROL_SPI_TX_CHECKSUM_EN undefined: SHALL send 80 bits with no checksum logic present.

Verification
REQ-031 Basic frame: CLK_DIV=4, Data0..4 = 0x005A, 0x010E, 0x01FF, 0x0000, 0x0003, start at cycle 0 -> CS low cycles 1-644; 80 rising SCK edges; captured words match; o_Done high at cycle 645 only.
REQ-032 Receiver loopback: frame Data0=0x1234, Data4=0x00AB into the ADC SPI receiver -> its Data0=0x1234, Data4=0x00AB, one data-received pulse.
REQ-033 Busy handling: extra start at cycle 300, inputs changed at cycle 10 -> single unaltered frame; next start is accepted at cycle 649 with o_Busy low.
REQ-034 Reset mid-frame: Reset at cycle 200 -> next cycle CS=1, SCK=0, Busy=0; no o_Done; new start then yields a full correct frame.
REQ-035 Checksum (CHECKSUM_EN): words 0xFFFF, 0x0002, 0, 0, 0 -> 96 bits, sixth word 0x0001; CS low for 772 cycles.

Source files
------------

// File: rtl/control_spi_tx_if.sv
// control_spi_tx_if -- request/data/SPI bundle for the control-frame SPI master.
//   master modport : drives i_Start, i_Data0..i_Data4; observes SPI pins, o_Busy, o_Done
//   slave modport  : the control_spi_tx block itself
interface control_spi_tx_if;
    logic        i_Start;
    logic [15:0] i_Data0;
    logic [15:0] i_Data1;
    logic [15:0] i_Data2;
    logic [15:0] i_Data3;
    logic [15:0] i_Data4;
    logic        o_SPI_CS;
    logic        o_SPI_Clock;
    logic        o_SPI_Data;
    logic        o_Busy;
    logic        o_Done;

    modport master (
        output i_Start, i_Data0, i_Data1, i_Data2, i_Data3, i_Data4,
        input  o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Done
    );

    modport slave (
        input  i_Start, i_Data0, i_Data1, i_Data2, i_Data3, i_Data4,
        output o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Done
    );
endinterface

// File: rtl/control_spi_tx.sv
// control_spi_tx -- SPI mode-0 master that sends the 5-word control frame
// (frequency, harmonic scale, scale initial, frequency offset, comb interval)
// MSB first to the ADC SPI receiver.
//   Main_Clock : system clock, rising edge
//   Reset      : synchronous, active-high
//   bus        : control_spi_tx_if.slave (i_Start, i_Data0..4 in;
//                o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Done out, all registered)
//   CLK_DIV    : Main_Clock cycles per SCK half-period (2..255)
// Optional feature: define CONTROL_SPI_TX_CHECKSUM_EN to append a sixth word
// holding the mod-2^16 sum of the five control words (96-bit frame).
module control_spi_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 Main_Clock,
    input  logic                 Reset,
    control_spi_tx_if.slave      bus
);

    localparam int unsigned WORD_W    = 16;
`ifdef CONTROL_SPI_TX_CHECKSUM_EN
    localparam int unsigned NUM_WORDS = 6;
`else
    localparam int unsigned NUM_WORDS = 5;
`endif
    localparam int unsigned FRAME_BITS = WORD_W * NUM_WORDS;
    localparam int unsigned DIV_W      = 8;
    localparam int unsigned BIT_CNT_W  = 7;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HIGH,
        SCK_LOW,
        GAP
    } state_t;

    state_t                  r_state;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    // Holds the bits still to be sent after the one on o_SPI_Data
    logic [FRAME_BITS-2:0]   r_shift;
    logic                    r_cs;
    logic                    r_sck;
    logic                    r_data;
    logic                    r_busy;
    logic                    r_done;

    logic [FRAME_BITS-1:0]   w_frame;
    logic                    w_div_end;

`ifdef CONTROL_SPI_TX_CHECKSUM_EN
    logic [WORD_W-1:0]       w_checksum;
    assign w_checksum = bus.i_Data0 + bus.i_Data1 + bus.i_Data2 + bus.i_Data3 + bus.i_Data4;
    assign w_frame    = {bus.i_Data0, bus.i_Data1, bus.i_Data2, bus.i_Data3, bus.i_Data4, w_checksum};
`else
    assign w_frame    = {bus.i_Data0, bus.i_Data1, bus.i_Data2, bus.i_Data3, bus.i_Data4};
`endif

    assign w_div_end = (r_div_cnt == DIV_LAST);

    // Frame sequencer; outputs are updated together with the state they belong to
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_data    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_Start) begin
                        r_state   <= SETUP;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_shift   <= w_frame[FRAME_BITS-2:0];
                        r_data    <= w_frame[FRAME_BITS-1];
                        r_cs      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_sck     <= 1'b1;
                        r_state   <= SCK_HIGH;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                SCK_HIGH: begin
                    // Leaving the high phase: the receiver has sampled, present the next bit
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_sck     <= 1'b0;
                        r_data    <= r_shift[FRAME_BITS-2];
                        r_shift   <= {r_shift[FRAME_BITS-3:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        r_state   <= SCK_LOW;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                SCK_LOW: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_cs    <= 1'b1;
                            r_data  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= GAP;
                        end else begin
                            r_sck   <= 1'b1;
                            r_state <= SCK_HIGH;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_SPI_CS    = r_cs;
    assign bus.o_SPI_Clock = r_sck;
    assign bus.o_SPI_Data  = r_data;
    assign bus.o_Busy      = r_busy;
    assign bus.o_Done      = r_done;

endmodule

// File: tb/tb_control_spi_tx.sv
// tb_control_spi_tx -- bench for control_spi_tx: timeline model of the expected
// SPI waveform, an SPI receiver that reassembles the words, and directed frames.
module tb_control_spi_tx;

    localparam int unsigned D = 4;
`ifdef CONTROL_SPI_TX_CHECKSUM_EN
    localparam int NB          = 96;
    localparam int LIT_CS_LEN  = 772;
    localparam int LIT_DONE_K  = 773;
`else
    localparam int NB          = 80;
    localparam int LIT_CS_LEN  = 644;
    localparam int LIT_DONE_K  = 645;
`endif
    localparam int CS_LEN   = D * (1 + 2 * NB);
    localparam int DONE_K   = CS_LEN + 1;
    localparam int BUSY_END = CS_LEN + D;

    logic Main_Clock;
    logic Reset;
    control_spi_tx_if bus_if ();

    control_spi_tx #(.CLK_DIV(D)) dut (
        .Main_Clock (Main_Clock),
        .Reset      (Reset),
        .bus        (bus_if.slave)
    );

    initial begin
        Main_Clock = 1'b0;
        forever #5 Main_Clock = ~Main_Clock;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int          cyc_m    = 0;
    int          m_s      = 0;
    bit          m_active = 1'b0;
    bit          m_valid  = 1'b0;
    logic [95:0] m_frame  = '0;

    always @(posedge Main_Clock) begin
        if (Reset) begin
            m_active = 1'b0;
            m_valid  = 1'b1;
        end else if (bus_if.i_Start && (!m_active || (cyc_m - m_s) > BUSY_END)) begin
            logic [15:0] w [5];
            logic [15:0] sum;
            w[0] = bus_if.i_Data0; w[1] = bus_if.i_Data1; w[2] = bus_if.i_Data2;
            w[3] = bus_if.i_Data3; w[4] = bus_if.i_Data4;
            sum = '0;
            m_frame = '0;
            for (int i = 0; i < 5; i++) begin
                m_frame[NB-1-16*i -: 16] = w[i];
                sum = sum + w[i];
            end
            if (NB == 96) m_frame[15:0] = sum;
            m_active = 1'b1;
            m_s      = cyc_m;
        end
        cyc_m = cyc_m + 1;
    end

    // ---------------- SPI receiver ----------------
    int          rx_bits  = 0;
    logic [95:0] rx_shift = '0;

    always @(posedge bus_if.o_SPI_Clock) begin
        if (bus_if.o_SPI_CS === 1'b0) begin
            rx_bits++;
            rx_shift = {rx_shift[94:0], bus_if.o_SPI_Data};
        end
    end

    // ---------------- per-cycle compare + frame statistics ----------------
    int   cs_low_cnt = 0;
    int   sck_rise   = 0;
    int   done_cnt   = 0;
    int   done_rel   = -1;
    logic prev_sck   = 1'b0;

    always @(negedge Main_Clock) begin
        if (m_valid) begin
            int   k;
            int   idx;
            logic e_cs, e_sck, e_dat, e_busy, e_done;
            k = cyc_m - m_s;
            e_cs = 1'b1; e_sck = 1'b0; e_dat = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (m_active) begin
                if (k >= 1 && k <= CS_LEN) begin
                    e_cs = 1'b0;
                    if (k > int'(D)) e_sck = (((k - int'(D) - 1) / int'(D)) % 2) == 0;
                    idx = (k - 1) / (2 * int'(D));
                    if (idx < NB) e_dat = m_frame[NB-1-idx];
                end
                e_done = (k == DONE_K);
                e_busy = (k >= 1 && k <= BUSY_END);
            end
            chk("cs",   32'(bus_if.o_SPI_CS),    32'(e_cs));
            chk("sck",  32'(bus_if.o_SPI_Clock), 32'(e_sck));
            chk("data", 32'(bus_if.o_SPI_Data),  32'(e_dat));
            chk("busy", 32'(bus_if.o_Busy),      32'(e_busy));
            chk("done", 32'(bus_if.o_Done),      32'(e_done));
            if (bus_if.o_SPI_CS === 1'b0) cs_low_cnt++;
            if (bus_if.o_SPI_Clock === 1'b1 && prev_sck === 1'b0) sck_rise++;
            prev_sck = bus_if.o_SPI_Clock;
            if (bus_if.o_Done === 1'b1) begin
                done_cnt++;
                done_rel = k;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Main_Clock);
        #1;
    endtask

    task automatic set_words(input logic [15:0] a, b, c, d, e);
        bus_if.i_Data0 = a; bus_if.i_Data1 = b; bus_if.i_Data2 = c;
        bus_if.i_Data3 = d; bus_if.i_Data4 = e;
    endtask

    task automatic clr_stats();
        rx_bits = 0; rx_shift = '0; cs_low_cnt = 0; sck_rise = 0;
        done_cnt = 0; done_rel = -1;
    endtask

    task automatic start_pulse();
        bus_if.i_Start = 1'b1;
        tick(1);
        bus_if.i_Start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] a, b, c, d, e);
        logic [15:0] exp_w [5];
        exp_w[0] = a; exp_w[1] = b; exp_w[2] = c; exp_w[3] = d; exp_w[4] = e;
        chk({tag, "_bits"}, 32'(rx_bits), 32'(NB));
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_word%0d", tag, i), 32'(rx_shift[NB-1-16*i -: 16]), 32'(exp_w[i]));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Reset = 1'b1;
        bus_if.i_Start = 1'b0;
        set_words(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick(3);
        chk("rst_cs",   32'(bus_if.o_SPI_CS),    32'd1);
        chk("rst_sck",  32'(bus_if.o_SPI_Clock), 32'd0);
        chk("rst_data", 32'(bus_if.o_SPI_Data),  32'd0);
        chk("rst_busy", 32'(bus_if.o_Busy),      32'd0);
        chk("rst_done", 32'(bus_if.o_Done),      32'd0);
        Reset = 1'b0;
        tick(2);

        // Basic frame
        set_words(16'h005A, 16'h010E, 16'h01FF, 16'h0000, 16'h0003);
        clr_stats();
        start_pulse();
        chk("basic_busy_rise", 32'(bus_if.o_Busy), 32'd1);
        tick(BUSY_END + 4);
        chk("basic_cs_len",    32'(cs_low_cnt), 32'(LIT_CS_LEN));
        chk("basic_sck_rises", 32'(sck_rise),   32'(NB));
        chk("basic_done_at",   32'(done_rel),   32'(LIT_DONE_K));
        check_frame("basic", 16'h005A, 16'h010E, 16'h01FF, 16'h0000, 16'h0003);

        // Busy handling: input change at 10, extra start at 300, restart at BUSY_END+1
        set_words(16'hA5A5, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        clr_stats();
        start_pulse();
        tick(9);
        set_words(16'h5A5A, 16'h0F0F, 16'hF0F0, 16'h8001, 16'h7FFE);
        tick(290);
        start_pulse();
        tick(BUSY_END + 1 - 301);
        chk("busy_low_at_restart", 32'(bus_if.o_Busy), 32'd0);
        check_frame("busy_f1", 16'hA5A5, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        clr_stats();
        start_pulse();
        chk("restart_busy", 32'(bus_if.o_Busy), 32'd1);
        tick(BUSY_END + 4);
        check_frame("busy_f2", 16'h5A5A, 16'h0F0F, 16'hF0F0, 16'h8001, 16'h7FFE);

        // Reset mid-frame
        set_words(16'hFFFF, 16'h8000, 16'h0001, 16'hC3C3, 16'h1234);
        clr_stats();
        start_pulse();
        tick(199);
        Reset = 1'b1;
        tick(1);
        chk("abort_cs",   32'(bus_if.o_SPI_CS),    32'd1);
        chk("abort_sck",  32'(bus_if.o_SPI_Clock), 32'd0);
        chk("abort_busy", 32'(bus_if.o_Busy),      32'd0);
        Reset = 1'b0;
        tick(CS_LEN + 10);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        clr_stats();
        start_pulse();
        tick(BUSY_END + 4);
        check_frame("after_abort", 16'hFFFF, 16'h8000, 16'h0001, 16'hC3C3, 16'h1234);

        // Reset and start in the same cycle: start discarded
        Reset = 1'b1;
        bus_if.i_Start = 1'b1;
        tick(1);
        Reset = 1'b0;
        bus_if.i_Start = 1'b0;
        tick(3);
        chk("rst_start_busy", 32'(bus_if.o_Busy),   32'd0);
        chk("rst_start_cs",   32'(bus_if.o_SPI_CS), 32'd1);

        // Receiver loopback
        set_words(16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h00AB);
        clr_stats();
        start_pulse();
        tick(BUSY_END + 4);
        chk("loop_word0", 32'(rx_shift[NB-1 -: 16]),  32'h1234);
        chk("loop_word4", 32'(rx_shift[NB-65 -: 16]), 32'h00AB);
        chk("loop_done",  32'(done_cnt), 32'd1);

`ifdef CONTROL_SPI_TX_CHECKSUM_EN
        // Checksum word wraps mod 2^16
        set_words(16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0000);
        clr_stats();
        start_pulse();
        tick(BUSY_END + 4);
        chk("csum_bits",   32'(rx_bits), 32'd96);
        chk("csum_word5",  32'(rx_shift[15:0]), 32'h0001);
        chk("csum_cs_len", 32'(cs_low_cnt), 32'd772);
`endif

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
